host_tx_arbiter: RTL and testbench

- Shares the single host-bound byte channel (add/data/full FIFO interface of the host I/O link) among NREQ requesters, e.g. the CPU MMIO path and a debug/boot monitor.
- Arbitration is round-robin with optional lock, so multi-byte messages go out atomically.
- Inserts a hold-off after every add so the FIFO full flag has time to update.
- Sits between the requesters and the host-link transmit FIFO.

---
 rtl/host_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_host_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/host_tx_arbiter.sv
// Round-robin arbiter that shares one host-bound byte FIFO among NREQ requesters.
// Supports locked bursts, a hold-off after each push, and an idle timeout for locked owners.
module host_tx_arbiter #(
  parameter int NREQ         = 2,
  parameter int HOLDOFF      = 1,
  parameter int MAX_BURST    = 16,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  input  logic              tx_full,
  output logic              tx_add,
  output logic [7:0]        tx_data,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);
  localparam logic [7:0] MAX_B     = 8'(MAX_BURST);
  localparam logic [7:0] LOCK_TO   = 8'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic [7:0]      idle_cnt_q, idle_cnt_d;
  logic            tx_add_q, tx_add_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [7:0]      req_bytes [NREQ];
  logic [PW-1:0]   owner_idx;
  logic [PW-1:0]   pick_idx;
  logic            pick_found;
  logic            owner_valid;
  logic            owner_lock;
  logic [7:0]      owner_byte;
  logic [PW-1:0]   owner_next;
  logic [7:0]      idle_inc;
  logic [7:0]      burst_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Owner index decoded from the one-hot grant register.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = PW'(i);
      end
    end
  end

  // First valid requester scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  assign owner_valid = req_valid[owner_idx];
  assign owner_lock  = req_lock[owner_idx];
  assign owner_byte  = req_bytes[owner_idx];
  assign owner_next  = (int'(owner_idx) == NREQ - 1) ? '0 : owner_idx + PW'(1);
  assign idle_inc    = idle_cnt_q + 8'd1;
  assign burst_inc   = (burst_cnt_q >= MAX_B) ? MAX_B : burst_cnt_q + 8'd1;

  always_comb begin
    logic release_now;
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    tx_add_d    = 1'b0;
    tx_data_d   = tx_data_q;
    release_now = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = ST_SEND;
        end
      end
      ST_SEND: begin
        // A full FIFO freezes the grant entirely, including the idle timer.
        if (!tx_full) begin
          if (owner_valid) begin
            tx_add_d    = 1'b1;
            tx_data_d   = owner_byte;
            burst_cnt_d = burst_inc;
            hold_cnt_d  = HOLD_INIT;
            idle_cnt_d  = '0;
            state_d     = ST_HOLD;
          end else if (!owner_lock) begin
            release_now = 1'b1;
          end else begin
            idle_cnt_d = idle_inc;
            if (idle_inc >= LOCK_TO) begin
              release_now = 1'b1;
            end
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q <= 4'd1) begin
          if (owner_lock && (burst_cnt_q < MAX_B)) begin
            state_d = ST_SEND;
          end else begin
            release_now = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    if (release_now) begin
      grant_d     = '0;
      rr_ptr_d    = owner_next;
      burst_cnt_d = '0;
      idle_cnt_d  = '0;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      hold_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      tx_add_q    <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      tx_add_q    <= tx_add_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign req_ready = ((state_q == ST_SEND) && !tx_full) ? grant_q : '0;
  assign grant     = grant_q;
  assign tx_add    = tx_add_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_host_tx_arbiter.sv
// Directed bench for host_tx_arbiter: a transaction-level reference model is checked every
// cycle, plus literal cycle-by-cycle expectations for each scenario.
module tb_host_tx_arbiter;

  localparam int NREQ = 2;
  localparam int HOLDOFF = 1;
  localparam int MAX_BURST = 16;
  localparam int LOCK_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_lock = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        tx_full = 1'b0;
  logic        tx_add;
  logic [7:0]  tx_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int        m_owner, m_hold, m_burst, m_idle, m_rr;
  logic      m_add;
  logic [7:0] m_data;

  logic [7:0] sent_q[$];
  int         sent_cyc[$];

  host_tx_arbiter #(
    .NREQ(NREQ), .HOLDOFF(HOLDOFF), .MAX_BURST(MAX_BURST), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_data(req_data), .req_ready(req_ready), .grant(grant), .tx_full(tx_full),
    .tx_add(tx_add), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_burst = 0; m_idle = 0; m_rr = 0;
    m_add = 1'b0; m_data = 8'h00;
  endtask

  // Predicts what the link looks like after the coming clock edge.
  task automatic model_step();
    logic nadd;
    logic rel;
    int   idx;
    nadd = 1'b0;
    rel  = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (m_owner < 0 && req_valid[idx]) begin
          m_owner = idx;
          m_hold  = 0;
        end
      end
    end else if (m_hold == 0) begin
      if (tx_full) begin
        nadd = 1'b0;
      end else if (req_valid[m_owner]) begin
        nadd    = 1'b1;
        m_data  = req_data[8*m_owner +: 8];
        m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
        m_hold  = HOLDOFF;
        m_idle  = 0;
      end else if (!req_lock[m_owner]) begin
        rel = 1'b1;
      end else begin
        m_idle++;
        if (m_idle >= LOCK_TIMEOUT) rel = 1'b1;
      end
    end else begin
      if (m_hold == 1) begin
        if (req_lock[m_owner] && m_burst < MAX_BURST) m_hold = 0;
        else rel = 1'b1;
      end else begin
        m_hold--;
      end
    end
    if (rel) begin
      m_rr = (m_owner + 1) % NREQ;
      m_owner = -1; m_burst = 0; m_idle = 0; m_hold = 0;
    end
    m_add = nadd;
  endtask

  always @(negedge clk) begin
    logic [1:0] g_e;
    logic [1:0] r_e;
    if (!reset_n) model_reset();
    g_e = '0;
    if (m_owner >= 0) g_e[m_owner] = 1'b1;
    r_e = (m_owner >= 0 && m_hold == 0 && !tx_full) ? g_e : 2'b00;
    check("grant", 32'(grant), 32'(g_e));
    check("req_ready", 32'(req_ready), 32'(r_e));
    check("tx_add", 32'(tx_add), 32'(m_add));
    check("tx_data", 32'(tx_data), 32'(m_data));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    if (tx_add === 1'b1) begin
      sent_q.push_back(tx_data);
      sent_cyc.push_back(cyc);
      $display("tx byte 0x%02h at cycle %0d", tx_data, cyc);
    end
    if (reset_n) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    req_valid = '0; req_lock = '0; req_data = '0; tx_full = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    sent_q.delete();
    sent_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single unlocked byte from req0.
    do_reset();
    req_valid = 2'b01; req_data = 16'h0041;
    #1;
    check("t1_c0_grant", 32'(grant), 32'h0);
    check("t1_c0_busy", 32'(busy), 32'h0);
    check("t1_c0_tx_data", 32'(tx_data), 32'h0);
    tick(); #1;
    check("t1_c1_grant", 32'(grant), 32'h1);
    check("t1_c1_ready", 32'(req_ready), 32'h1);
    tick(); #1;
    check("t1_c2_tx_add", 32'(tx_add), 32'h1);
    check("t1_c2_tx_data", 32'(tx_data), 32'h41);
    req_valid = 2'b00;
    tick(); #1;
    check("t1_c3_grant", 32'(grant), 32'h0);
    check("t1_c3_busy", 32'(busy), 32'h0);
    check("t1_c3_tx_add", 32'(tx_add), 32'h0);

    // Two unlocked requesters alternate, one byte every 3 cycles.
    do_reset();
    req_valid = 2'b11; req_data = 16'h2010;
    for (int i = 0; i < 14; i++) tick();
    check("t2_count", 32'(sent_q.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
      check("t2_byte", 32'(sent_q[i]), (i % 2 == 0) ? 32'h10 : 32'h20);
      if (i > 0) check("t2_gap", 32'(sent_cyc[i] - sent_cyc[i-1]), 32'd3);
    end
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Locked burst capped at MAX_BURST, then req1, then req0 resumes.
    do_reset();
    req_valid = 2'b11; req_lock = 2'b01; req_data = 16'h6655;
    for (int i = 0; i < 45; i++) tick();
    check("t3_count", 32'(sent_q.size() >= 18), 32'h1);
    for (int i = 0; i < 18 && i < sent_q.size(); i++) begin
      if (i < 16) check("t3_burst_byte", 32'(sent_q[i]), 32'h55);
      if (i > 0 && i < 16) check("t3_burst_gap", 32'(sent_cyc[i] - sent_cyc[i-1]), 32'd2);
      if (i == 16) check("t3_req1_byte", 32'(sent_q[i]), 32'h66);
      if (i == 17) check("t3_resume_byte", 32'(sent_q[i]), 32'h55);
    end
    req_valid = 2'b00; req_lock = 2'b00;
    tick(); tick(); tick();

    // FIFO full stall for 5 SEND cycles; byte is the one present at accept.
    do_reset();
    req_valid = 2'b01; req_data = 16'h0011; tx_full = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      #1;
      check("t4_stall_ready", 32'(req_ready), 32'h0);
      check("t4_stall_tx_add", 32'(tx_add), 32'h0);
      check("t4_stall_grant", 32'(grant), 32'h1);
      tick();
    end
    tx_full = 1'b0; req_data = 16'h005A;
    #1;
    check("t4_accept_ready", 32'(req_ready), 32'h1);
    tick(); #1;
    check("t4_tx_add", 32'(tx_add), 32'h1);
    check("t4_tx_data", 32'(tx_data), 32'h5A);
    req_valid = 2'b00;
    tick(); tick();

    // Locked owner goes idle: timeout release, then req1 is granted.
    do_reset();
    req_valid = 2'b11; req_lock = 2'b01; req_data = 16'h8877;
    tick(); tick();
    req_valid = 2'b10;
    tick(); #1;
    check("t5_c3_grant", 32'(grant), 32'h1);
    tick(); tick(); tick(); #1;
    check("t5_c6_grant", 32'(grant), 32'h1);
    tick(); #1;
    check("t5_c7_grant", 32'(grant), 32'h0);
    tick(); #1;
    check("t5_c8_grant", 32'(grant), 32'h2);
    req_valid = 2'b00; req_lock = 2'b00;
    tick(); tick(); tick(); tick();

    // Reset asserted in the tx_add cycle.
    do_reset();
    req_valid = 2'b11; req_data = 16'h3199;
    tick(); tick(); #1;
    check("t6_tx_add_before", 32'(tx_add), 32'h1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_tx_add", 32'(tx_add), 32'h0);
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_ready", 32'(req_ready), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); #1;
    check("t6_restart_grant", 32'(grant), 32'h1);
    req_valid = 2'b00;
    tick(); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
